// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle control sequencer for the RISC-V core. Walks each
//               instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
//               latches the fetched instruction and its PC, and computes
//               word-addressed branch/jump targets for the PC register.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int ADDRESS_SIZE = 6,
    parameter int INS_W        = 32,
    localparam int PC_W        = 2 ** ADDRESS_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  instruction_ptr,
    input  logic [INS_W-1:0] imem_rdata,
    input  logic             imem_ack,
    input  logic             alu_zero,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             pc_write,
    output logic             pc_src,
    output logic [PC_W-1:0]  new_pc,
    output logic [INS_W-1:0] ir,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i_alu  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [1:0] c_wb_alu  = 2'b00;
    localparam logic [1:0] c_wb_mem  = 2'b01;
    localparam logic [1:0] c_wb_link = 2'b10;

    state_t            r_state;
    state_t            w_next;
    logic [INS_W-1:0]  r_ir;
    logic [PC_W-1:0]   r_old_pc;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_is_r, w_is_i_alu, w_is_load, w_is_store;
    logic              w_is_branch, w_is_jal, w_supported;
    logic              w_taken;

    logic signed [PC_W-1:0] w_b_imm;
    logic signed [PC_W-1:0] w_j_imm;
    logic signed [PC_W-1:0] w_imm;
    logic signed [PC_W-1:0] w_word_off;

    logic              w_imem_req, w_dmem_req, w_dmem_we;
    logic              w_pc_write, w_pc_src, w_reg_write, w_illegal;
    logic [1:0]        w_wb_sel;

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_is_r      = (w_opcode == c_op_r);
    assign w_is_i_alu  = (w_opcode == c_op_i_alu);
    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_jal    = (w_opcode == c_op_jal);
    assign w_supported = w_is_r | w_is_i_alu | w_is_load | w_is_store
                       | w_is_branch | w_is_jal;

    // BEQ taken on zero, BNE taken on non-zero, other funct3 never taken
    assign w_taken = ((w_funct3 == 3'b000) &&  alu_zero)
                   | ((w_funct3 == 3'b001) && !alu_zero);

    // Byte offsets are sign-extended, then scaled to words because the PC
    // counts instructions rather than bytes.
    assign w_b_imm = {{(PC_W-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25],
                      r_ir[11:8], 1'b0};
    assign w_j_imm = {{(PC_W-21){r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20],
                      r_ir[30:21], 1'b0};
    assign w_imm      = w_is_jal ? w_j_imm : w_b_imm;
    assign w_word_off = w_imm >>> 2;
    assign new_pc     = r_old_pc + $unsigned(w_word_off);

    // State register; reset abandons any outstanding memory request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Capture the instruction and its own PC on the fetch handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir     <= '0;
            r_old_pc <= '0;
        end else if ((r_state == S_FETCH) && imem_ack) begin
            r_ir     <= imem_rdata;
            r_old_pc <= instruction_ptr;
        end
    end

    // Next-state and control decode per state
    always_comb begin
        w_next      = r_state;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        w_reg_write = 1'b0;
        w_wb_sel    = c_wb_alu;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_supported) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_EXECUTE: begin
                if (w_is_r || w_is_i_alu) begin
                    w_next = S_WRITEBACK;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEMORY;
                end else if (w_is_branch) begin
                    w_pc_write = w_taken;
                    w_pc_src   = w_taken;
                    w_next     = S_FETCH;
                end else if (w_is_jal) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = 1'b1;
                    w_next     = S_WRITEBACK;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (dmem_ack) begin
                    w_next = w_is_load ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                w_reg_write = 1'b1;
                if (w_is_load) begin
                    w_wb_sel = c_wb_mem;
                end else if (w_is_jal) begin
                    w_wb_sel = c_wb_link;
                end else begin
                    w_wb_sel = c_wb_alu;
                end
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Outputs are forced low for as long as reset is held
    assign imem_req  = w_imem_req  & ~rst;
    assign dmem_req  = w_dmem_req  & ~rst;
    assign dmem_we   = w_dmem_we   & ~rst;
    assign pc_write  = w_pc_write  & ~rst;
    assign pc_src    = w_pc_src    & ~rst;
    assign reg_write = w_reg_write & ~rst;
    assign illegal   = w_illegal   & ~rst;
    assign wb_sel    = rst ? 2'b00 : w_wb_sel;
    assign ir        = r_ir;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam int PC_W = 64;

    logic            clk;
    logic            rst;
    logic [PC_W-1:0] instruction_ptr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;
    logic            alu_zero;
    logic            dmem_ack;
    logic            imem_req;
    logic            dmem_req;
    logic            dmem_we;
    logic            pc_write;
    logic            pc_src;
    logic [PC_W-1:0] new_pc;
    logic [31:0]     ir;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            illegal;
    logic [2:0]      state;

    int checks = 0;
    int errors = 0;
    logic fetch_pw, fetch_ps, fetch_req;

    pc_sequencer #(.ADDRESS_SIZE(6), .INS_W(32)) dut (
        .clk(clk), .rst(rst), .instruction_ptr(instruction_ptr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .alu_zero(alu_zero),
        .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .pc_write(pc_write), .pc_src(pc_src),
        .new_pc(new_pc), .ir(ir), .reg_write(reg_write), .wb_sel(wb_sel),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completes one fetch handshake from a negedge in FETCH; returns at the
    // next negedge (DECODE) with the fetch-cycle PC controls captured.
    task automatic fetch(input logic [63:0] ptr, input logic [31:0] instr);
        instruction_ptr = ptr;
        imem_rdata      = instr;
        imem_ack        = 1'b1;
        #1;
        fetch_pw  = pc_write;
        fetch_ps  = pc_src;
        fetch_req = imem_req;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (imem_req !== 1'b0 || pc_write !== 1'b0 || dmem_req !== 1'b0 || reg_write !== 1'b0 || illegal !== 1'b0)
            begin errors++; $display("FAIL reset_outputs: got req=%b pw=%b dreq=%b rw=%b ill=%b expected all 0", imem_req, pc_write, dmem_req, reg_write, illegal); end
        checks++; if (ir !== 32'h0 || new_pc !== 64'h0) begin errors++; $display("FAIL reset_regs: got ir=%h new_pc=%h expected 0", ir, new_pc); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req: got %b expected 1", imem_req); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_memory();
        logic [2:0] exp_st [4];
        logic       exp_rw [4];
        exp_st = '{3'd1, 3'd2, 3'd4, 3'd0};
        exp_rw = '{1'b0, 1'b0, 1'b1, 1'b0};
        fetch(64'd3, 32'h00002003);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_entry: got state=%0d dreq=%b expected 3/1", state, dmem_req); end
        rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || dmem_req !== 1'b0) begin errors++; $display("FAIL async_reset: got state=%0d dreq=%b expected 0/0", state, dmem_req); end
        checks++; if (ir !== 32'h0) begin errors++; $display("FAIL async_reset_ir: got %h expected 0", ir); end
        @(negedge clk);
        rst = 1'b0;
        fetch(64'd7, 32'h00000013);
        checks++; if (fetch_pw !== 1'b1 || fetch_ps !== 1'b0 || fetch_req !== 1'b1)
            begin errors++; $display("FAIL addi_fetch: got pw=%b ps=%b req=%b expected 1/0/1", fetch_pw, fetch_ps, fetch_req); end
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL addi_seq[%0d]: got state=%0d expected %0d", i, state, exp_st[i]); end
            checks++; if (reg_write !== exp_rw[i] || pc_write !== 1'b0)
                begin errors++; $display("FAIL addi_ctl[%0d]: got rw=%b pw=%b expected %b/0", i, reg_write, pc_write, exp_rw[i]); end
            if (i == 2) begin
                checks++; if (wb_sel !== 2'b00) begin errors++; $display("FAIL addi_wb_sel: got %b expected 00", wb_sel); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        fetch(64'd10, 32'hFE000EE3);
        #1;
        checks++; if (state !== 3'd1 || ir !== 32'hFE000EE3) begin errors++; $display("FAIL beq_decode: got state=%0d ir=%h expected 1/fe000ee3", state, ir); end
        @(negedge clk);
        alu_zero = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || pc_src !== 1'b1) begin errors++; $display("FAIL beq_taken_ctl: got pw=%b ps=%b expected 1/1", pc_write, pc_src); end
        checks++; if (new_pc !== 64'd9) begin errors++; $display("FAIL beq_target: got %0d expected 9", new_pc); end
        @(negedge clk);
        alu_zero = 1'b0;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq_return: got state=%0d expected 0", state); end
        @(negedge clk);
        fetch(64'd10, 32'hFE000EE3);
        @(negedge clk);
        alu_zero = 1'b0;
        #1;
        checks++; if (state !== 3'd2 || pc_write !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got state=%0d pw=%b expected 2/0", state, pc_write); end
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL beq_nt_return: got state=%0d expected 0", state); end
        @(negedge clk);
        fetch(64'd20, 32'hFE001EE3);
        @(negedge clk);
        alu_zero = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b1 || pc_src !== 1'b1 || new_pc !== 64'd19)
            begin errors++; $display("FAIL bne_taken: got pw=%b ps=%b new_pc=%0d expected 1/1/19", pc_write, pc_src, new_pc); end
        @(negedge clk);
        fetch(64'd30, 32'hFE005EE3);
        @(negedge clk);
        alu_zero = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL funct3_101_not_taken: got pw=%b expected 0", pc_write); end
        @(negedge clk);
        alu_zero = 1'b0;
    endtask

    task automatic test_jal();
        fetch(64'd0, 32'hFF9FF06F);
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd2 || pc_write !== 1'b1 || pc_src !== 1'b1)
            begin errors++; $display("FAIL jal_exec: got state=%0d pw=%b ps=%b expected 2/1/1", state, pc_write, pc_src); end
        checks++; if (new_pc !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL jal_wrap: got %h expected fffffffffffffffe", new_pc); end
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd4 || reg_write !== 1'b1 || wb_sel !== 2'b10 || pc_write !== 1'b0)
            begin errors++; $display("FAIL jal_wb: got state=%0d rw=%b wb=%b pw=%b expected 4/1/10/0", state, reg_write, wb_sel, pc_write); end
        @(negedge clk);
    endtask

    task automatic test_load_store();
        fetch(64'd5, 32'h00002003);
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd2 || dmem_req !== 1'b0) begin errors++; $display("FAIL load_exec: got state=%0d dreq=%b expected 2/0", state, dmem_req); end
        @(negedge clk);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dmem_ack = (i == 2);
            #1;
            checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b0 || pc_write !== 1'b0)
                begin errors++; $display("FAIL load_mem[%0d]: got state=%0d dreq=%b we=%b pw=%b expected 3/1/0/0", i, state, dmem_req, dmem_we, pc_write); end
            @(negedge clk);
            imem_ack = 1'b0;
        end
        dmem_ack = 1'b0;
        #1;
        checks++; if (state !== 3'd4 || reg_write !== 1'b1 || wb_sel !== 2'b01)
            begin errors++; $display("FAIL load_wb: got state=%0d rw=%b wb=%b expected 4/1/01", state, reg_write, wb_sel); end
        checks++; if (ir !== 32'h00002003) begin errors++; $display("FAIL stray_imem_ack_ir: got %h expected 00002003", ir); end
        @(negedge clk);
        fetch(64'd6, 32'h00002023);
        @(negedge clk);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || reg_write !== 1'b0)
            begin errors++; $display("FAIL store_mem: got state=%0d dreq=%b we=%b rw=%b expected 3/1/1/0", state, dmem_req, dmem_we, reg_write); end
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        checks++; if (state !== 3'd0 || reg_write !== 1'b0) begin errors++; $display("FAIL store_return: got state=%0d rw=%b expected 0/0", state, reg_write); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        fetch(64'd8, 32'h0000007F);
        #1;
        checks++; if (state !== 3'd1 || illegal !== 1'b1 || pc_write !== 1'b0)
            begin errors++; $display("FAIL illegal_decode: got state=%0d ill=%b pw=%b expected 1/1/0", state, illegal, pc_write); end
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd0 || illegal !== 1'b0 || reg_write !== 1'b0 || dmem_req !== 1'b0 || pc_write !== 1'b0)
            begin errors++; $display("FAIL illegal_after: got state=%0d ill=%b rw=%b dreq=%b pw=%b expected 0/0/0/0/0", state, illegal, reg_write, dmem_req, pc_write); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        imem_rdata = 32'h12345678;
        imem_ack   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state !== 3'd0 || imem_req !== 1'b1 || pc_write !== 1'b0 || ir !== 32'h0000007F)
                begin errors++; $display("FAIL stall[%0d]: got state=%0d req=%b pw=%b ir=%h expected 0/1/0/0000007f", i, state, imem_req, pc_write, ir); end
            @(negedge clk);
        end
        fetch(64'd9, 32'h00000013);
        #1;
        checks++; if (fetch_pw !== 1'b1 || ir !== 32'h00000013 || state !== 3'd1)
            begin errors++; $display("FAIL stall_release: got pw=%b ir=%h state=%0d expected 1/00000013/1", fetch_pw, ir, state); end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        instruction_ptr = '0;
        imem_rdata      = '0;
        imem_ack        = 1'b0;
        alu_zero        = 1'b0;
        dmem_ack        = 1'b0;
        test_reset();
        test_reset_mid_memory();
        test_branch();
        test_jal();
        test_load_store();
        test_illegal();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
